// File: rtl/fp_multiplier_pkg.sv
// fp_multiplier_pkg: float-format constants shared by the multiplier, divider and adder
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [9:0] EXP_BIAS = 10'd127;
  localparam logic [4:0] MUL_STEPS = 5'd24;
  localparam logic [4:0] MUL_DONE = 5'd25;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam int MAN_LSB = 0;
endpackage

// File: rtl/fp_multiplier_if.sv
// fp_multiplier_if: run/stall request bus carrying operands x, y and product z
interface fp_multiplier_if;
  logic run;
  logic [31:0] x;
  logic [31:0] y;
  logic stall;
  logic [31:0] z;
  modport master (output run, x, y, input stall, z);
  modport slave (input run, x, y, output stall, z);
endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round half-up and pack sign/exponent/mantissa into a single float
// ports: sign, zero (flush to 0), e (unbiased-sum exponent minus bias, 10-bit two's complement),
//        m (26-bit raw mantissa, leading one in bit 25 or 24), z (packed result)
module fp_round_pack (
  input  logic        sign,
  input  logic        zero,
  input  logic [9:0]  e,
  input  logic [25:0] m,
  output logic [31:0] z
);
  logic [24:0] z0;
  logic [24:0] r;
  logic [9:0]  e1;
  assign z0 = m[25] ? m[25:1] : m[24:0];
  // r is (z0 + 1) >> 1: r[24] is the rounding carry, r[23] the leading one
  assign r  = {1'b0, z0[24:1]} + {24'd0, z0[0]};
  assign e1 = e + {9'd0, m[25]} + {9'd0, r[24]};
  assign z  = zero ? 32'h0 :
              (e1[9] || e1 == 10'd0) ? 32'h0 :
              (e1 >= 10'd255) ? {sign, 8'hFF, 23'h0} :
              {sign, e1[7:0], r[23] ? r[22:0] : 23'h0};
endmodule

// File: rtl/fp_multiplier.sv
// fp_multiplier: 25-cycle shift-add single-precision multiplier
// ports: clk, rst (async active-low), bus (run/x/y in, stall/z out)
module fp_multiplier
  import fp_pkg::*;
(
  input logic clk,
  input logic rst,
  fp_multiplier_if.slave bus
);
  logic [4:0]  s;
  logic [47:0] p;
  logic [24:0] sum;
  logic [9:0]  e;
  logic [7:0]  xe;
  logic [7:0]  ye;
  assign xe  = bus.x[EXP_MSB:EXP_LSB];
  assign ye  = bus.y[EXP_MSB:EXP_LSB];
  assign e   = {2'b0, xe} + {2'b0, ye} - EXP_BIAS;
  assign sum = {1'b0, p[47:24]} + (p[0] ? {2'b01, bus.y[MAN_MSB:MAN_LSB]} : 25'd0);
  assign bus.stall = bus.run & (s != MUL_DONE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s <= 5'd0;
      p <= 48'h0;
    end else begin
      s <= !bus.run ? 5'd0 : (s == MUL_DONE) ? s : s + 5'd1;
      if (bus.run && s == 5'd0) p <= {24'h0, 1'b1, bus.x[MAN_MSB:MAN_LSB]};
      else if (bus.run && s != MUL_DONE) p <= {sum, p[23:1]};
    end
  fp_round_pack u_round (
    .sign(bus.x[SIGN_BIT] ^ bus.y[SIGN_BIT]),
    .zero(xe == 8'd0 || ye == 8'd0),
    .e(e),
    .m(p[47:22]),
    .z(bus.z)
  );
endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier: scoreboard bench for fp_multiplier with directed operand vectors
module tb_fp_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fp_multiplier_if bus();
  fp_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] exp_q[$];
  int checks = 0;
  int passed = 0;
  int cnt = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  always @(negedge clk) begin
    if (!rst || !bus.run) cnt = 0;
    else if (bus.stall) cnt = cnt + 1;
    else if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_output: got z=%h expected no output", bus.z);
    end else begin
      chk("product", {32'h0, bus.z}, {32'h0, exp_q.pop_front()});
      chk("latency", 64'(cnt), 64'd25);
    end
  end
  task automatic wait_done();
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!bus.stall) break;
    end
    if (n == 40) chk("timeout", 64'd1, 64'd0);
    @(posedge clk); #1 bus.run = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    exp_q.push_back(e);
    bus.x = a;
    bus.y = b;
    bus.run = 1'b1;
    wait_done();
  endtask
  logic [31:0] vx[8] = '{32'h3FC00000, 32'hBF800000, 32'h3FFFFFFF, 32'h00000000,
                         32'h7F000000, 32'h00800000, 32'h40400000, 32'hFF000000};
  logic [31:0] vy[8] = '{32'h40000000, 32'h40000000, 32'h3F800001, 32'h40000000,
                         32'h7F000000, 32'h00800000, 32'h40400000, 32'h7F000000};
  logic [31:0] vz[8] = '{32'h40400000, 32'hC0000000, 32'h40000000, 32'h00000000,
                         32'h7F800000, 32'h00000000, 32'h41100000, 32'hFF800000};
  initial begin
    bus.run = 1'b0;
    bus.x = 32'h0;
    bus.y = 32'h0;
    #1;
    chk("reset_stall_idle", {63'h0, bus.stall}, 64'd0);
    chk("reset_s", {59'h0, dut.s}, 64'd0);
    chk("reset_p", {16'h0, dut.p}, 64'd0);
    bus.run = 1'b1;
    #1 chk("reset_stall_run", {63'h0, bus.stall}, 64'd1);
    bus.run = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) op(vx[i], vy[i], vz[i]);
    exp_q.push_back(32'h40400000);
    bus.x = 32'h3FC00000;
    bus.y = 32'h40000000;
    bus.run = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("abort_s10", {59'h0, dut.s}, 64'd10);
    bus.run = 1'b0;
    @(posedge clk); #1 chk("abort_s0", {59'h0, dut.s}, 64'd0);
    bus.run = 1'b1;
    wait_done();
    exp_q.push_back(32'hC0000000);
    bus.x = 32'hBF800000;
    bus.y = 32'h40000000;
    bus.run = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("rst_s12", {59'h0, dut.s}, 64'd12);
    #2 rst = 1'b0;
    #1 chk("rst_async_s", {59'h0, dut.s}, 64'd0);
    chk("rst_async_p", {16'h0, dut.p}, 64'd0);
    chk("rst_stall", {63'h0, bus.stall}, 64'd1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    wait_done();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
